// File: rtl/bus_arbiter_3_if.sv
// Bus-side signal bundle for the 3-source round-robin bus arbiter.
// master drives requests and source words; slave is the arbiter.
interface bus_arbiter_3_if #(
  parameter int WIDTH = 32
);
  logic [2:0]       req;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [2:0]       gnt;
  logic [2:0]       sig;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;

  modport master (
    output req, in0, in1, in2,
    input  gnt, sig, bus_out, bus_valid
  );

  modport slave (
    input  req, in0, in1, in2,
    output gnt, sig, bus_out, bus_valid
  );
endinterface

// File: rtl/bus_arbiter_3.sv
// Round-robin arbiter/sequencer for a 3-source shared bus: one-hot grant,
// mux select, registered bus word, hold-time limit and one-cycle turnaround.
module bus_arbiter_3 #(
  parameter int WIDTH    = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic             clock_i,
  input  logic             clear_i,
  bus_arbiter_3_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_e;

  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       hold_q, hold_d;
  logic [2:0]       gnt_q, gnt_d;
  logic [2:0]       sig_q, sig_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic             valid_q, valid_d;

  logic [1:0]       c1, c2, win;
  logic             any_req;
  logic [2:0]       others;
  logic [WIDTH-1:0] sel_word;

  // Rotation starts after the last owner, so the previous owner ranks lowest.
  always_comb begin
    c1      = (last_q == 2'd2) ? 2'd0 : last_q + 2'd1;
    c2      = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
    any_req = |bus.req;
    if (bus.req[c1])      win = c1;
    else if (bus.req[c2]) win = c2;
    else                  win = last_q;
    others  = bus.req & ~(3'b001 << last_q);
    case (last_q)
      2'd0:    sel_word = bus.in0;
      2'd1:    sel_word = bus.in1;
      default: sel_word = bus.in2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    sig_d   = sig_q;
    bus_d   = bus_q;
    valid_d = 1'b0;
    case (state_q)
      GRANT: begin
        bus_d   = sel_word;
        valid_d = 1'b1;
        if (!bus.req[last_q] || (hold_q == HOLD_MAX && others != 3'b000)) begin
          state_d = TURN;
          gnt_d   = 3'b000;
          sig_d   = 3'd3;
        end else if (hold_q == HOLD_MAX) begin
          hold_d  = 8'd1;
        end else begin
          hold_d  = hold_q + 8'd1;
        end
      end
      default: begin
        if (any_req) begin
          state_d = GRANT;
          gnt_d   = 3'b001 << win;
          sig_d   = {1'b0, win};
          last_d  = win;
          hold_d  = 8'd1;
        end else begin
          state_d = IDLE;
          gnt_d   = 3'b000;
          sig_d   = 3'd3;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge clear_i) begin
    if (!clear_i) begin
      state_q <= IDLE;
      last_q  <= 2'd2;
      hold_q  <= 8'd0;
      gnt_q   <= 3'b000;
      sig_q   <= 3'd3;
      bus_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sig_q   <= sig_d;
      bus_q   <= bus_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.sig       = sig_q;
  assign bus.bus_out   = bus_q;
  assign bus.bus_valid = valid_q;
endmodule
